// File: rtl/lane_dly_step_ctrl_pkg.sv
// Shared types and encodings for the lane delay-line step controller.
package lane_dly_step_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StPulse,
      StGap,
      StPrePause,
      StLoad,
      StPostPause,
      StDone
   } state_e;

   typedef enum logic [1:0] {
      RspOk          = 2'b00,
      RspOutOfRange  = 2'b01,
      RspSaturated   = 2'b10
   } rsp_status_e;

   localparam logic OpMove = 1'b0;
   localparam logic OpLoad = 1'b1;
   localparam logic SelRx  = 1'b0;
   localparam logic SelTx  = 1'b1;

   // True when one more step in the given direction would leave 0..255.
   function automatic logic step_blocked(logic [7:0] tap, logic dir);
      return dir ? (tap == 8'hFF) : (tap == 8'h00);
   endfunction

endpackage

// File: rtl/lane_dly_step_ctrl_if.sv
// Command/response handshake between a requester and the step controller.
interface lane_dly_step_ctrl_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_op;
   logic       cmd_sel;
   logic       cmd_dir;
   logic [7:0] cmd_taps;
   logic       rsp_valid;
   logic [1:0] rsp_status;
   logic [7:0] rsp_steps;

   modport master (
      output cmd_valid, cmd_op, cmd_sel, cmd_dir, cmd_taps,
      input  cmd_ready, rsp_valid, rsp_status, rsp_steps
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_sel, cmd_dir, cmd_taps,
      output cmd_ready, rsp_valid, rsp_status, rsp_steps
   );

endinterface

// File: rtl/lane_tap_counter.sv
// 8-bit saturating up/down tap counter with synchronous clear.
module lane_tap_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       inc,
   input  logic       dec,
   output logic [7:0] tap
);

   logic [7:0] tap_q, tap_d;

   // Clear wins; simultaneous inc/dec holds; ends of range hold.
   always_comb begin
      tap_d = tap_q;
      if (clr) begin
         tap_d = 8'd0;
      end else if (inc && !dec && (tap_q != 8'hFF)) begin
         tap_d = tap_q + 8'd1;
      end else if (dec && !inc && (tap_q != 8'h00)) begin
         tap_d = tap_q - 8'd1;
      end
   end

   // Tap state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tap_q <= 8'd0;
      end else begin
         tap_q <= tap_d;
      end
   end

   assign tap = tap_q;

endmodule

// File: rtl/lane_dly_step_ctrl.sv
// Sequences MOVE and LOAD operations on the RX/TX DQS delay lines of a lane
// controller, tracking the tap offset of each line.
module lane_dly_step_ctrl
   import lane_dly_step_ctrl_pkg::*;
#(
   parameter int unsigned MOVE_GAP     = 4,
   parameter int unsigned PAUSE_CYCLES = 2
) (
   input  logic                        fab_clk,
   input  logic                        reset_n,
   lane_dly_step_ctrl_if.slave         cmd_bus,
   output logic                        delay_line_sel,
   output logic                        delay_line_load,
   output logic                        delay_line_direction,
   output logic                        delay_line_move,
   output logic                        hs_io_clk_pause,
   input  logic                        rx_delay_line_out_of_range,
   input  logic                        tx_delay_line_out_of_range,
   output logic [7:0]                  rx_tap,
   output logic [7:0]                  tx_tap
);

   localparam logic [3:0] GapLast   = 4'(MOVE_GAP - 1);
   localparam logic [3:0] PauseLast = 4'(PAUSE_CYCLES - 1);

   state_e      state_q, state_d;
   logic        sel_q, sel_d;
   logic        dir_q, dir_d;
   logic [7:0]  rem_q, rem_d;
   logic [7:0]  steps_q, steps_d;
   logic [3:0]  cnt_q, cnt_d;
   rsp_status_e fin_status;
   logic        step_en, clr_en;

   logic        cmd_ready_q, rsp_valid_q;
   rsp_status_e rsp_status_q;
   logic [7:0]  rsp_steps_q;
   logic        move_q, load_q, pause_q, dl_sel_q, dl_dir_q;

   logic        sel_oor;
   logic [7:0]  sel_tap, tap_after;
   logic        line_active_d, move_active_d;

   // Only the selected line's range flag and tap value matter.
   assign sel_oor   = sel_q ? tx_delay_line_out_of_range : rx_delay_line_out_of_range;
   assign sel_tap   = sel_q ? tx_tap : rx_tap;
   assign tap_after = dir_q ? (sel_tap + 8'd1) : (sel_tap - 8'd1);

   lane_tap_counter u_rx_cnt (
      .clk   (fab_clk),
      .rst_n (reset_n),
      .clr   (clr_en && (sel_q == SelRx)),
      .inc   (step_en && (sel_q == SelRx) && dir_q),
      .dec   (step_en && (sel_q == SelRx) && !dir_q),
      .tap   (rx_tap)
   );

   lane_tap_counter u_tx_cnt (
      .clk   (fab_clk),
      .rst_n (reset_n),
      .clr   (clr_en && (sel_q == SelTx)),
      .inc   (step_en && (sel_q == SelTx) && dir_q),
      .dec   (step_en && (sel_q == SelTx) && !dir_q),
      .tap   (tx_tap)
   );

   // Next-state logic: command capture, pulse/gap sequencing, load pause window.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      dir_d      = dir_q;
      rem_d      = rem_q;
      steps_d    = steps_q;
      cnt_d      = cnt_q;
      fin_status = RspOk;
      step_en    = 1'b0;
      clr_en     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cmd_bus.cmd_valid && cmd_ready_q) begin
               sel_d   = cmd_bus.cmd_sel;
               dir_d   = cmd_bus.cmd_dir;
               rem_d   = cmd_bus.cmd_taps;
               steps_d = 8'd0;
               if (cmd_bus.cmd_op == OpLoad) begin
                  state_d = StPrePause;
                  cnt_d   = PauseLast;
               end else if (cmd_bus.cmd_taps == 8'd0) begin
                  state_d = StDone;
               end else begin
                  state_d = StSetup;
               end
            end
         end
         StSetup: begin
            if (step_blocked(sel_tap, dir_q)) begin
               state_d    = StDone;
               fin_status = RspSaturated;
            end else begin
               state_d = StPulse;
            end
         end
         StPulse: begin
            state_d = StGap;
            cnt_d   = GapLast;
         end
         StGap: begin
            if (sel_oor) begin
               state_d    = StDone;
               fin_status = RspOutOfRange;
            end else if (cnt_q == 4'd0) begin
               step_en = 1'b1;
               steps_d = steps_q + 8'd1;
               rem_d   = rem_q - 8'd1;
               if (rem_q == 8'd1) begin
                  state_d = StDone;
               end else if (step_blocked(tap_after, dir_q)) begin
                  // Next step would leave range: stop before pulsing it.
                  state_d    = StDone;
                  fin_status = RspSaturated;
               end else begin
                  state_d = StPulse;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StPrePause: begin
            if (cnt_q == 4'd0) begin
               state_d = StLoad;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StLoad: begin
            clr_en  = 1'b1;
            state_d = StPostPause;
            cnt_d   = PauseLast;
         end
         StPostPause: begin
            if (cnt_q == 4'd0) begin
               state_d = StDone;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // FSM and command working registers.
   always_ff @(posedge fab_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         sel_q   <= 1'b0;
         dir_q   <= 1'b0;
         rem_q   <= 8'd0;
         steps_q <= 8'd0;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         dir_q   <= dir_d;
         rem_q   <= rem_d;
         steps_q <= steps_d;
         cnt_q   <= cnt_d;
      end
   end

   assign line_active_d = (state_d == StSetup) || (state_d == StPulse) || (state_d == StGap) ||
                          (state_d == StPrePause) || (state_d == StLoad) ||
                          (state_d == StPostPause);
   assign move_active_d = (state_d == StSetup) || (state_d == StPulse) || (state_d == StGap);

   // Outputs registered from next state so they line up with state_q.
   always_ff @(posedge fab_clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_ready_q  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_status_q <= RspOk;
         rsp_steps_q  <= 8'd0;
         move_q       <= 1'b0;
         load_q       <= 1'b0;
         pause_q      <= 1'b0;
         dl_sel_q     <= 1'b0;
         dl_dir_q     <= 1'b0;
      end else begin
         cmd_ready_q <= (state_d == StIdle);
         rsp_valid_q <= (state_d == StDone);
         if (state_d == StDone) begin
            rsp_status_q <= fin_status;
            rsp_steps_q  <= steps_d;
         end
         move_q   <= (state_d == StPulse);
         load_q   <= (state_d == StLoad);
         pause_q  <= (state_d == StPrePause) || (state_d == StLoad) ||
                     (state_d == StPostPause);
         dl_sel_q <= line_active_d && sel_d;
         dl_dir_q <= move_active_d && dir_d;
      end
   end

   assign cmd_bus.cmd_ready    = cmd_ready_q;
   assign cmd_bus.rsp_valid    = rsp_valid_q;
   assign cmd_bus.rsp_status   = rsp_status_q;
   assign cmd_bus.rsp_steps    = rsp_steps_q;
   assign delay_line_move      = move_q;
   assign delay_line_load      = load_q;
   assign hs_io_clk_pause      = pause_q;
   assign delay_line_sel       = dl_sel_q;
   assign delay_line_direction = dl_dir_q;

endmodule

// File: tb/tb_lane_dly_step_ctrl.sv
// Directed bench for lane_dly_step_ctrl with MOVE_GAP=4, PAUSE_CYCLES=2.
module tb_lane_dly_step_ctrl;

   logic       fab_clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       dl_sel, dl_load, dl_dir, dl_move, pause;
   logic       rx_oor, tx_oor;
   logic [7:0] rx_tap, tx_tap;

   int total = 0;
   int bad   = 0;

   int         n_move, first_move, last_move, gap_bad, n_load, load_at, n_pause;
   int         rsp_at, sd_bad, overlap, rv_seen;
   logic [1:0] got_status;
   logic [7:0] got_steps;

   always #5 fab_clk = ~fab_clk;

   lane_dly_step_ctrl_if bus ();

   lane_dly_step_ctrl #(
      .MOVE_GAP     (4),
      .PAUSE_CYCLES (2)
   ) dut (
      .fab_clk                    (fab_clk),
      .reset_n                    (reset_n),
      .cmd_bus                    (bus),
      .delay_line_sel             (dl_sel),
      .delay_line_load            (dl_load),
      .delay_line_direction       (dl_dir),
      .delay_line_move            (dl_move),
      .hs_io_clk_pause            (pause),
      .rx_delay_line_out_of_range (rx_oor),
      .tx_delay_line_out_of_range (tx_oor),
      .rx_tap                     (rx_tap),
      .tx_tap                     (tx_tap)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge fab_clk);
      #1;
   endtask

   // Issue one command and watch the lane-controller outputs until the response.
   // Cycle index 0 is the first cycle after the accepting edge.
   task automatic run_cmd(input logic op, input logic sel, input logic dir,
                          input logic [7:0] taps, input int oor_at, input string tag);
      int w;
      w = 0;
      while (!bus.cmd_ready && w < 20) begin
         tick();
         w++;
      end
      check_val({tag, ".ready"}, 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_sel   = sel;
      bus.cmd_dir   = dir;
      bus.cmd_taps  = taps;
      tick();
      // Scramble the inputs: the running command must not see them.
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = ~op;
      bus.cmd_sel   = ~sel;
      bus.cmd_dir   = ~dir;
      bus.cmd_taps  = ~taps;
      n_move = 0; first_move = -1; last_move = -1; gap_bad = 0;
      n_load = 0; load_at = -1; n_pause = 0; rsp_at = -1;
      sd_bad = 0; overlap = 0; got_status = 2'b11; got_steps = 8'hEE;
      for (int c = 0; c < 100; c++) begin
         if (dl_move) begin
            if (last_move >= 0 && (c - last_move) != 5) gap_bad++;
            if (first_move < 0) first_move = c;
            last_move = c;
            n_move++;
            if (dl_sel !== sel || dl_dir !== dir) sd_bad++;
         end
         if (dl_load) begin
            n_load++;
            load_at = c;
            if (dl_sel !== sel) sd_bad++;
         end
         if (dl_move && dl_load) overlap++;
         if (pause) n_pause++;
         if (bus.rsp_valid) begin
            rsp_at     = c;
            got_status = bus.rsp_status;
            got_steps  = bus.rsp_steps;
            break;
         end
         if (oor_at >= 0 && c >= oor_at) begin
            if (sel) tx_oor = 1'b1;
            else     rx_oor = 1'b1;
         end
         tick();
      end
      if (oor_at >= 0) begin
         if (sel) tx_oor = 1'b0;
         else     rx_oor = 1'b0;
      end
      check_val({tag, ".overlap"}, 32'(overlap), 32'd0);
      check_val({tag, ".sel_dir"}, 32'(sd_bad), 32'd0);
      check_val({tag, ".spacing"}, 32'(gap_bad), 32'd0);
      tick();
      check_val({tag, ".rsp_pulse"}, 32'(bus.rsp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 1'b0;
      bus.cmd_sel   = 1'b0;
      bus.cmd_dir   = 1'b0;
      bus.cmd_taps  = 8'd0;
      rx_oor        = 1'b0;
      tx_oor        = 1'b0;
      repeat (2) tick();

      // Reset state.
      check_val("rst.ready",  32'(bus.cmd_ready),  32'd0);
      check_val("rst.move",   32'(dl_move),        32'd0);
      check_val("rst.load",   32'(dl_load),        32'd0);
      check_val("rst.pause",  32'(pause),          32'd0);
      check_val("rst.sel",    32'(dl_sel),         32'd0);
      check_val("rst.dir",    32'(dl_dir),         32'd0);
      check_val("rst.rx_tap", 32'(rx_tap),         32'd0);
      check_val("rst.tx_tap", 32'(tx_tap),         32'd0);
      check_val("rst.rsp_v",  32'(bus.rsp_valid),  32'd0);
      check_val("rst.status", 32'(bus.rsp_status), 32'd0);
      check_val("rst.steps",  32'(bus.rsp_steps),  32'd0);
      @(negedge fab_clk);
      reset_n = 1'b1;
      tick();
      check_val("rel.ready", 32'(bus.cmd_ready), 32'd1);

      // MOVE with zero taps: straight to DONE.
      run_cmd(1'b0, 1'b0, 1'b1, 8'd0, -1, "taps0");
      check_val("taps0.rsp_at", 32'(rsp_at),     32'd0);
      check_val("taps0.status", 32'(got_status), 32'd0);
      check_val("taps0.steps",  32'(got_steps),  32'd0);
      check_val("taps0.moves",  32'(n_move),     32'd0);
      check_val("taps0.pause",  32'(n_pause),    32'd0);
      check_val("taps0.loads",  32'(n_load),     32'd0);

      // Decrement from 0 is refused before any pulse.
      run_cmd(1'b0, 1'b0, 1'b0, 8'd2, -1, "sat_lo");
      check_val("sat_lo.rsp_at", 32'(rsp_at),     32'd1);
      check_val("sat_lo.status", 32'(got_status), 32'd2);
      check_val("sat_lo.steps",  32'(got_steps),  32'd0);
      check_val("sat_lo.moves",  32'(n_move),     32'd0);
      check_val("sat_lo.rx_tap", 32'(rx_tap),     32'd0);

      // RX +3, with the unselected TX range flag held high throughout.
      tx_oor = 1'b1;
      run_cmd(1'b0, 1'b0, 1'b1, 8'd3, -1, "rx3");
      tx_oor = 1'b0;
      check_val("rx3.rsp_at", 32'(rsp_at),     32'd16);
      check_val("rx3.moves",  32'(n_move),     32'd3);
      check_val("rx3.first",  32'(first_move), 32'd1);
      check_val("rx3.last",   32'(last_move),  32'd11);
      check_val("rx3.status", 32'(got_status), 32'd0);
      check_val("rx3.steps",  32'(got_steps),  32'd3);
      check_val("rx3.rx_tap", 32'(rx_tap),     32'd3);
      check_val("rx3.tx_tap", 32'(tx_tap),     32'd0);

      // TX +10, out-of-range raised mid 4th gap (gap cycles 17..20).
      run_cmd(1'b0, 1'b1, 1'b1, 8'd10, 18, "tx_oor");
      check_val("tx_oor.moves",  32'(n_move),     32'd4);
      check_val("tx_oor.rsp_at", 32'(rsp_at),     32'd19);
      check_val("tx_oor.status", 32'(got_status), 32'd1);
      check_val("tx_oor.steps",  32'(got_steps),  32'd3);
      check_val("tx_oor.tx_tap", 32'(tx_tap),     32'd3);
      check_val("tx_oor.rx_tap", 32'(rx_tap),     32'd3);

      // TX +2 brings TX_TAP to 5.
      run_cmd(1'b0, 1'b1, 1'b1, 8'd2, -1, "tx2");
      check_val("tx2.rsp_at", 32'(rsp_at),    32'd11);
      check_val("tx2.steps",  32'(got_steps), 32'd2);
      check_val("tx2.tx_tap", 32'(tx_tap),    32'd5);

      // LOAD TX: pause 5 cycles, load in the 3rd.
      run_cmd(1'b1, 1'b1, 1'b0, 8'h55, -1, "load_tx");
      check_val("load_tx.pause",   32'(n_pause),    32'd5);
      check_val("load_tx.loads",   32'(n_load),     32'd1);
      check_val("load_tx.load_at", 32'(load_at),    32'd2);
      check_val("load_tx.moves",   32'(n_move),     32'd0);
      check_val("load_tx.rsp_at",  32'(rsp_at),     32'd5);
      check_val("load_tx.status",  32'(got_status), 32'd0);
      check_val("load_tx.steps",   32'(got_steps),  32'd0);
      check_val("load_tx.tx_tap",  32'(tx_tap),     32'd0);
      check_val("load_tx.rx_tap",  32'(rx_tap),     32'd3);

      // RX -5 from 3: three steps then saturated at 0.
      run_cmd(1'b0, 1'b0, 1'b0, 8'd5, -1, "sat_mid");
      check_val("sat_mid.rsp_at", 32'(rsp_at),     32'd16);
      check_val("sat_mid.moves",  32'(n_move),     32'd3);
      check_val("sat_mid.status", 32'(got_status), 32'd2);
      check_val("sat_mid.steps",  32'(got_steps),  32'd3);
      check_val("sat_mid.rx_tap", 32'(rx_tap),     32'd0);

      // Response fields hold after DONE.
      repeat (3) tick();
      check_val("hold.status", 32'(bus.rsp_status), 32'd2);
      check_val("hold.steps",  32'(bus.rsp_steps),  32'd3);
      check_val("hold.rsp_v",  32'(bus.rsp_valid),  32'd0);

      // Reset during the 2nd gap cycle of a TX +5 move.
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 1'b0;
      bus.cmd_sel   = 1'b1;
      bus.cmd_dir   = 1'b1;
      bus.cmd_taps  = 8'd5;
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      check_val("mid.pulse", 32'(dl_move), 32'd1);
      tick();
      tick();
      check_val("mid.sel_pre", 32'(dl_sel), 32'd1);
      check_val("mid.dir_pre", 32'(dl_dir), 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check_val("mid.move",  32'(dl_move),       32'd0);
      check_val("mid.pause", 32'(pause),         32'd0);
      check_val("mid.load",  32'(dl_load),       32'd0);
      check_val("mid.sel",   32'(dl_sel),        32'd0);
      check_val("mid.dir",   32'(dl_dir),        32'd0);
      check_val("mid.ready", 32'(bus.cmd_ready), 32'd0);
      rv_seen = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus.rsp_valid) rv_seen++;
      end
      @(negedge fab_clk);
      reset_n = 1'b1;
      tick();
      check_val("mid.ready_rel", 32'(bus.cmd_ready),  32'd1);
      check_val("mid.status",    32'(bus.rsp_status), 32'd0);
      check_val("mid.tx_tap",    32'(tx_tap),         32'd0);
      for (int i = 0; i < 8; i++) begin
         if (bus.rsp_valid) rv_seen++;
         tick();
      end
      check_val("mid.no_rsp", 32'(rv_seen), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lane_dly_step_ctrl.md
LANE_DLY_STEP_CTRL -- requirements
Module: lane_dly_step_ctrl

Interface
REQ-001 The block SHALL have parameter MOVE_GAP, default 4, giving idle cycles after each DELAY_LINE_MOVE pulse (range 2-15).
REQ-002 The block SHALL have parameter PAUSE_CYCLES, default 2, giving HS_IO_CLK_PAUSE guard cycles before and after a load pulse (range 1-15).
REQ-003 FAB_CLK  input  1  sole clock; all logic rising-edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 CMD_VALID  input  1  command request.
REQ-006 CMD_READY  output  1  block can accept a command.
REQ-007 CMD_OP  input  1  0 = MOVE, 1 = LOAD.
REQ-008 CMD_SEL  input  1  0 = RX DQS delay line, 1 = TX DQS delay line.
REQ-009 CMD_DIR  input  1  1 = increment delay, 0 = decrement.
REQ-010 CMD_TAPS  input  8  number of tap steps for MOVE; ignored for LOAD.
REQ-011 RSP_VALID  output  1  one-cycle completion strobe.
REQ-012 RSP_STATUS  output  2  00 OK, 01 OUT_OF_RANGE abort, 10 counter saturated.
REQ-013 RSP_STEPS  output  8  steps actually applied by the completed command.
REQ-014 DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE, HS_IO_CLK_PAUSE  output  1 each  to the lane controller.
REQ-015 RX_DELAY_LINE_OUT_OF_RANGE, TX_DELAY_LINE_OUT_OF_RANGE  input  1 each  from the lane controller.
REQ-016 RX_TAP, TX_TAP  output  8 each  tracked tap offset per delay line.

Function
REQ-017 Command accepted on the cycle CMD_VALID and CMD_READY are both high; CMD_READY SHALL be high only in IDLE.
REQ-018 Accepted CMD_OP/SEL/DIR/TAPS SHALL be registered; later input changes do not affect the running command.
REQ-019 FSM states: IDLE, SETUP, PULSE, GAP, PRE_PAUSE, LOAD, POST_PAUSE, DONE.
REQ-020 MOVE with CMD_TAPS=0: IDLE->DONE; RSP_VALID the next cycle, status OK, RSP_STEPS 0, no pulses.
REQ-021 MOVE with CMD_TAPS>0: IDLE->SETUP (SEL, DIRECTION driven, MOVE low, 1 cycle)->PULSE (MOVE high exactly 1 cycle)->GAP (MOVE_GAP cycles).
REQ-022 DELAY_LINE_SEL and DELAY_LINE_DIRECTION SHALL remain stable from SETUP through the final GAP cycle of the command.
REQ-023 On the last GAP cycle, if the selected OUT_OF_RANGE input is low, the selected tap counter SHALL step by one in CMD_DIR and the step count SHALL increment.
REQ-024 If the selected OUT_OF_RANGE input is high on any GAP cycle, that step SHALL NOT be counted, remaining steps SHALL be abandoned, and the FSM SHALL go to DONE with status 01.
REQ-025 After a counted step: remaining>0 -> PULSE (SETUP not repeated); remaining=0 -> DONE with status 00.
REQ-026 A step that would take a counter above 255 or below 0 SHALL NOT be pulsed; the FSM SHALL go to DONE with status 10.
REQ-027 LOAD: PRE_PAUSE (HS_IO_CLK_PAUSE high, PAUSE_CYCLES)->LOAD (DELAY_LINE_LOAD high 1 cycle, pause held)->POST_PAUSE (pause held, PAUSE_CYCLES)->DONE, status 00, RSP_STEPS 0.
REQ-028 LOAD SHALL clear the selected tap counter to 0 in the LOAD state; the other counter is unchanged.
REQ-029 DONE SHALL last 1 cycle with RSP_VALID high and RSP_STATUS/RSP_STEPS valid, then return to IDLE; RSP_STATUS/RSP_STEPS hold until the next DONE.
REQ-030 The OUT_OF_RANGE input of the unselected line SHALL be ignored.
REQ-031 DELAY_LINE_MOVE and DELAY_LINE_LOAD SHALL never be high in the same cycle; all outputs SHALL be registered.

Reset
REQ-032 While RESET_N is low: FSM IDLE, CMD_READY 0, all strobe and control outputs 0, RX_TAP and TX_TAP 0, RSP_STATUS 00, RSP_STEPS 0.
REQ-033 CMD_READY SHALL rise on the first FAB_CLK edge after RESET_N deasserts.
REQ-034 Reset mid-command SHALL abandon the command without RSP_VALID and drop MOVE, LOAD, and PAUSE immediately.

Structure
REQ-035 A shared package SHALL hold the FSM state enum, the RSP_STATUS encodings, and the CMD_OP/CMD_SEL encodings.
REQ-036 A single sub-module, lane_tap_counter (8-bit saturating up/down counter with clear), SHALL be instantiated once per delay line.

Verification
REQ-037 MOVE RX, DIR=1, TAPS=3, MOVE_GAP=4: three 1-cycle MOVE pulses spaced 5 cycles apart, SEL=0, RX_TAP 0->3, status 00, steps 3.
REQ-038 MOVE TX, TAPS=10, TX_DELAY_LINE_OUT_OF_RANGE raised during the 4th GAP: exactly 4 pulses, TX_TAP=3, status 01, steps 3.
REQ-039 RX_TAP=0, MOVE RX, DIR=0, TAPS=2: no MOVE pulse, status 10, steps 0, RX_TAP stays 0.
REQ-040 LOAD TX after TX_TAP=5, PAUSE_CYCLES=2: PAUSE high for 5 cycles with LOAD in cycle 3 only, TX_TAP=0, RX_TAP unchanged.
REQ-041 RESET_N dropped on the 2nd GAP cycle of a TAPS=5 move: outputs 0 immediately, no RSP_VALID, CMD_READY 1 after release.
REQ-042 MOVE with TAPS=0: RSP_VALID on the cycle after acceptance, status 00, no DELAY_LINE_* activity.
